// File: rtl/sysid_boot_check.sv
// Boot-time check of the system-ID slave, then 1-cycle-latency CPU read passthrough.
// Optional: define SYSID_LOCKOUT_EN to return a fixed poison word in FAIL instead of slave data.
module sysid_boot_check #(
  parameter logic [31:0] EXP_ID        = 32'h0000_0000,
  parameter logic [31:0] EXP_TS        = 32'd1382618285,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  input  logic        cpu_address,
  input  logic        cpu_read,
  output logic        cpu_waitrequest,
  output logic [31:0] cpu_readdata,
  output logic        cpu_readdatavalid,
  output logic        boot_done,
  output logic        boot_ok,
  output logic [1:0]  retry_count,
  output logic [1:0]  id_mismatch
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned RTY_W  = 2;
`ifdef SYSID_LOCKOUT_EN
  localparam logic [DATA_W-1:0] LOCKOUT_WORD = 32'hBAD1_D000;
`endif

  typedef enum logic [2:0] {
    S_SETTLE, S_RD_ID, S_RD_TS, S_CHECK, S_PASS, S_FAIL
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   id_q, id_d, ts_q, ts_d;
  logic [RTY_W-1:0]    retry_q, retry_d, mism_q, mism_d;
  logic                done_q, done_d, ok_q, ok_d, wait_q, wait_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  // Registered state, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_SETTLE;
      cnt_q    <= '0;
      id_q     <= '0;
      ts_q     <= '0;
      retry_q  <= '0;
      mism_q   <= '0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      wait_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      ts_q     <= ts_d;
      retry_q  <= retry_d;
      mism_q   <= mism_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Next-state, slave address mux and CPU read capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    ts_d        = ts_q;
    retry_d     = retry_q;
    mism_d      = mism_q;
    done_d      = done_q;
    ok_d        = ok_q;
    wait_d      = wait_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    sid_address = 1'b0;

    case (state_q)
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_RD_ID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_ID: begin
        id_d    = sid_readdata;
        state_d = S_RD_TS;
      end
      S_RD_TS: begin
        sid_address = 1'b1;
        ts_d        = sid_readdata;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        mism_d = {ts_q != EXP_TS, id_q != EXP_ID};
        if (mism_d == '0) begin
          state_d = S_PASS;
          done_d  = 1'b1;
          ok_d    = 1'b1;
          wait_d  = 1'b0;
        end else begin
          retry_d = retry_q + RTY_W'(1);
          if (retry_d == RTY_W'(MAX_RETRY)) begin
            state_d = S_FAIL;
            done_d  = 1'b1;
            wait_d  = 1'b0;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end
      S_PASS, S_FAIL: begin
`ifdef SYSID_LOCKOUT_EN
        if (state_q == S_FAIL) begin
          if (cpu_read) begin
            rdata_d  = LOCKOUT_WORD;
            rvalid_d = 1'b1;
          end
        end else
`endif
        begin
          sid_address = cpu_address;
          if (cpu_read) begin
            rdata_d  = sid_readdata;
            rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = S_SETTLE;
    endcase
  end

  assign cpu_waitrequest   = wait_q;
  assign cpu_readdata      = rdata_q;
  assign cpu_readdatavalid = rvalid_q;
  assign boot_done         = done_q;
  assign boot_ok           = ok_q;
  assign retry_count       = retry_q;
  assign id_mismatch       = mism_q;

endmodule

// File: doc/sysid_boot_check.md
Name: sysid_boot_check

Overview:
Boot-time sequencer and access arbiter in front of the 1-bit-address, 32-bit, combinational system-ID slave (address 0 = ID word, address 1 = build timestamp). After reset it owns the slave, reads both words, compares them against expected values and reports pass/fail with bounded retries. It then hands the slave to the CPU-side Avalon-MM read port, with registered readdata and fixed latency.

Parameters:
EXP_ID, 32'h0000_0000, expected ID word (address 0)
EXP_TS, 32'd1382618285, expected timestamp word (address 1)
SETTLE_CYCLES, 4, cycles waited after reset/retry before first read (1..255)
MAX_RETRY, 3, mismatching check passes allowed before FAIL (1..3)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
sid_address  out  1  address to system-ID slave
sid_readdata  in  32  combinational read data from system-ID slave
cpu_address  in  1  CPU word address
cpu_read  in  1  CPU read request
cpu_waitrequest  out  1  stall CPU read
cpu_readdata  out  32  registered read data to CPU
cpu_readdatavalid  out  1  one-cycle pulse, data valid
boot_done  out  1  check finished (pass or fail), sticky until reset
boot_ok  out  1  IDs matched, sticky until reset
retry_count  out  2  mismatching passes so far (saturates at MAX_RETRY)
id_mismatch  out  2  bit0 = ID mismatch, bit1 = timestamp mismatch, last completed pass

Behaviour:
- Reset (reset_n low at clock edge): state=SETTLE, settle counter=0, retry_count=0, id_mismatch=0, boot_done=0, boot_ok=0, cpu_readdata=0, cpu_readdatavalid=0, sid_address=0, cpu_waitrequest=1.
- States: SETTLE -> RD_ID -> RD_TS -> CHECK -> {PASS | SETTLE | FAIL}.
- SETTLE: counter increments each cycle. Exit to RD_ID on the cycle the counter equals SETTLE_CYCLES-1. Counter clears on exit.
- RD_ID: sid_address=0; sid_readdata is captured into id_reg at the clock edge; next state RD_TS.
- RD_TS: sid_address=1; capture into ts_reg; next state CHECK.
- CHECK: id_mismatch <= {ts_reg!=EXP_TS, id_reg!=EXP_ID}.
  - Both match: go to PASS; boot_ok=1 and boot_done=1 from the first PASS cycle.
  - Any mismatch: retry_count+1. If the new count == MAX_RETRY, go to FAIL (boot_done=1, boot_ok=0); otherwise go to SETTLE.
- Minimum boot time with SETTLE_CYCLES=4 and an immediate match: 4+1+1+1 = 7 cycles from reset release to boot_done=1.
- While not in PASS/FAIL:
  - cpu_waitrequest=1 unconditionally.
  - cpu_read is ignored; no readdatavalid is produced.
  - sid_address is owned by the FSM.
- PASS/FAIL (CPU phase):
  - cpu_waitrequest=0.
  - sid_address = cpu_address combinationally.
  - When cpu_read=1: cpu_readdata <= sid_readdata and cpu_readdatavalid <= 1 at the same edge. Fixed read latency is 1 cycle.
  - Back-to-back reads give one result per cycle, in order.
  - When cpu_read=0: readdatavalid <= 0 and cpu_readdata holds its last value.
- cpu_read asserted across the handover edge: the first accepted read is the one sampled in the first PASS/FAIL cycle. Nothing is queued from earlier cycles.
- Reset mid-boot or mid-read: all state and outputs return to reset values on that edge; any in-flight readdatavalid is dropped.
- PASS and FAIL are terminal until reset.

Optional Feature:
SYSID_LOCKOUT_EN
- Defined: in FAIL, CPU reads are still accepted (waitrequest=0, readdatavalid after 1 cycle), but cpu_readdata returns 32'hBAD1_D000 for both addresses and sid_address stays 0.
- Not defined: FAIL behaves exactly like PASS for CPU reads (passthrough), and the constant and gating logic are absent.

Test Plan:
- Matching slave (addr0=0, addr1=1382618285), defaults -> boot_done and boot_ok rise 7 cycles after reset release; retry_count=0; id_mismatch=0.
- Slave ID word 32'h1 permanently -> three passes, id_mismatch=2'b01, retry_count=3, boot_done=1, boot_ok=0.
- Timestamp wrong on first pass only, then correct -> retry_count=1, boot_ok=1, total boot 14 cycles.
- After PASS, cpu_read held 4 cycles with address 1,0,1,1 -> readdatavalid high 4 consecutive cycles, each 1 cycle late, data 1382618285, 0, 1382618285, 1382618285.
- cpu_read held high from reset -> waitrequest=1 and no readdatavalid until PASS; first valid data is one cycle after the first PASS cycle.
- reset_n low for 1 cycle during RD_TS, then a matching slave -> outputs reset that edge; boot completes 7 cycles after release. With SYSID_LOCKOUT_EN and a failing ID -> CPU reads return 32'hBAD1_D000.
